// File: rtl/jedro_1_lsu_pkg.sv
// Shared LSU types for the jedro_1 store path.
// Covers the memory access size encoding, byte-enable patterns and the buffered store entry layout.
package jedro_1_lsu_pkg;

    localparam int unsigned LSU_ADDR_WIDTH = 32;
    localparam int unsigned LSU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE    = 2'b00,
        MEM_SIZE_HALF    = 2'b01,
        MEM_SIZE_WORD    = 2'b10,
        MEM_SIZE_ILLEGAL = 2'b11
    } mem_size_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [LSU_ADDR_WIDTH-3:0] addr;
        logic [3:0]                be;
        logic [LSU_DATA_WIDTH-1:0] wdata;
    } store_entry_t;

endpackage

// File: rtl/jedro_1_store_align.sv
// Store alignment: turns size + low address bits into a legality flag,
// byte enables and lane-replicated write data.
module jedro_1_store_align
    import jedro_1_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic        legal_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    // Size decode; illegal sizes and misaligned addresses yield no byte enables
    always_comb begin
        legal_o = 1'b0;
        be_o    = BE_NONE;
        wdata_o = wdata_i;
        case (mem_size_e'(size_i))
            MEM_SIZE_BYTE: begin
                legal_o = 1'b1;
                be_o    = BE_BYTE << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                if (addr_lo_i[0] == 1'b0) begin
                    legal_o = 1'b1;
                    be_o    = BE_HALF << addr_lo_i;
                end else begin
                    legal_o = 1'b0;
                    be_o    = BE_NONE;
                end
            end
            MEM_SIZE_WORD: begin
                if (addr_lo_i == 2'b00) begin
                    legal_o = 1'b1;
                    be_o    = BE_WORD;
                end else begin
                    legal_o = 1'b0;
                    be_o    = BE_NONE;
                end
            end
            default: begin
                legal_o = 1'b0;
                be_o    = BE_NONE;
            end
        endcase
    end

endmodule

// File: rtl/jedro_1_store_buffer.sv
// Store buffer between the jedro_1 LSU and the byte-write data RAM port:
// aligns stores, queues them in a FIFO, drains on grant and reports load hazards.
module jedro_1_store_buffer
    import jedro_1_lsu_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [1:0]            st_size_i,
    input  logic [ADDR_WIDTH-1:0] st_addr_i,
    input  logic [DATA_WIDTH-1:0] st_wdata_i,
    output logic                  misaligned_o,
    output logic [ADDR_WIDTH-1:0] misaligned_addr_o,
    input  logic                  ld_valid_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    output logic                  ld_hazard_o,
    output logic                  empty_o,
    input  logic                  ram_grant_i,
    output logic [3:0]            ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic                  align_legal_s;
    logic [3:0]            align_be_s;
    logic [DATA_WIDTH-1:0] align_wdata_s;
    store_entry_t          entries_r [DEPTH];
    store_entry_t          head_s;
    store_entry_t          new_entry_s;
    logic [PTR_W:0]        wr_ptr_r;
    logic [PTR_W:0]        rd_ptr_r;
    logic [PTR_W:0]        count_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  reject_s;
    logic                  pop_s;
    logic [3:0]            ram_we_s;
    logic                  hazard_s;
    logic                  misaligned_r;
    logic [ADDR_WIDTH-1:0] misaligned_addr_r;
    logic [1:0]            unused_ld_lo_s;

    jedro_1_store_align u_align (
        .size_i    (st_size_i),
        .addr_lo_i (st_addr_i[1:0]),
        .wdata_i   (st_wdata_i),
        .legal_o   (align_legal_s),
        .be_o      (align_be_s),
        .wdata_o   (align_wdata_s)
    );

    // Wrap bit differs with equal index bits only when every slot is occupied
    assign count_s = wr_ptr_r - rd_ptr_r;
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

    assign push_s   = st_valid_i & ~full_s & align_legal_s;
    assign reject_s = st_valid_i & ~full_s & ~align_legal_s;
    assign head_s   = entries_r[rd_ptr_r[PTR_W-1:0]];
    assign pop_s    = (ram_we_s != 4'b0000);

    assign new_entry_s.addr  = st_addr_i[ADDR_WIDTH-1:2];
    assign new_entry_s.be    = align_be_s;
    assign new_entry_s.wdata = align_wdata_s;

    assign unused_ld_lo_s = ld_addr_i[1:0];

    // Drain the head whenever the RAM port is granted
    always_comb begin
        ram_we_s = 4'b0000;
        if (!empty_s && ram_grant_i) begin
            ram_we_s = head_s.be;
        end else begin
            ram_we_s = 4'b0000;
        end
    end

    // Load hazard scan over occupied slots, head included while it drains
    always_comb begin
        logic [PTR_W-1:0] off_v;
        hazard_s = 1'b0;
        off_v    = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_v = PTR_W'(i) - rd_ptr_r[PTR_W-1:0];
            if (({1'b0, off_v} < count_s) &&
                (entries_r[i].addr == ld_addr_i[ADDR_WIDTH-1:2])) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // FIFO pointers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; occupancy is tracked by the pointers alone
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            entries_r[wr_ptr_r[PTR_W-1:0]] <= new_entry_s;
        end
    end

    // Reject pulse and sticky reject address
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            misaligned_r      <= 1'b0;
            misaligned_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            misaligned_r <= reject_s;
            if (reject_s) begin
                misaligned_addr_r <= st_addr_i;
            end
        end
    end

    assign st_ready_o        = ~full_s;
    assign empty_o           = empty_s;
    assign misaligned_o      = misaligned_r;
    assign misaligned_addr_o = misaligned_addr_r;
    assign ld_hazard_o       = ld_valid_i & hazard_s;
    assign ram_we_o          = ram_we_s;
    assign ram_addr_o        = {head_s.addr, 2'b00};
    assign ram_wdata_o       = head_s.wdata;

endmodule

// File: tb/tb_jedro_1_store_buffer.sv
// Self-checking bench for jedro_1_store_buffer: directed scenarios plus random
// traffic checked against a queue-based store model and a byte-level memory model.
module tb_jedro_1_store_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [1:0]  st_size_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_wdata_i;
    logic        misaligned_o;
    logic [31:0] misaligned_addr_o;
    logic        ld_valid_i;
    logic [31:0] ld_addr_i;
    logic        ld_hazard_o;
    logic        empty_o;
    logic        ram_grant_i;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;

    jedro_1_store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_size_i(st_size_i),
        .st_addr_i(st_addr_i), .st_wdata_i(st_wdata_i),
        .misaligned_o(misaligned_o), .misaligned_addr_o(misaligned_addr_o),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_hazard_o(ld_hazard_o),
        .empty_o(empty_o), .ram_grant_i(ram_grant_i), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } st_t;

    st_t         q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        exp_mis = 1'b0;
    logic [31:0] exp_mis_addr = 32'h0;
    logic [7:0]  mmem [64];
    logic [31:0] bram [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        nb = 1 << size;
        return (size != 2'd3) && ((addr % nb) == 0);
    endfunction

    function automatic logic [3:0] m_be(input st_t s);
        int nb;
        nb = 1 << s.size;
        return 4'(((1 << nb) - 1) << s.addr[1:0]);
    endfunction

    function automatic logic [31:0] m_lane(input st_t s);
        logic [31:0] r;
        int nb;
        nb = 1 << s.size;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = s.data[8*(k % nb) +: 8];
        return r;
    endfunction

    task automatic step(input logic v, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic g, input logic lv,
                        input logic [31:0] la);
        bit   hz;
        bit   rdy;
        st_t  s;
        int   nb;
        st_valid_i = v; st_size_i = sz; st_addr_i = a; st_wdata_i = d;
        ram_grant_i = g; ld_valid_i = lv; ld_addr_i = la;
        #3;
        chk("ready", 64'(st_ready_o), 64'(q.size() < DEPTH));
        chk("empty", 64'(empty_o), 64'(q.size() == 0));
        chk("mis", 64'(misaligned_o), 64'(exp_mis));
        chk("mis_addr", 64'(misaligned_addr_o), 64'(exp_mis_addr));
        hz = 1'b0;
        foreach (q[i]) if (q[i].addr[31:2] == la[31:2]) hz = 1'b1;
        chk("hazard", 64'(ld_hazard_o), 64'(lv && hz));
        if (q.size() > 0 && g) begin
            chk("we", 64'(ram_we_o), 64'(m_be(q[0])));
            chk("waddr", 64'(ram_addr_o), 64'({q[0].addr[31:2], 2'b00}));
            chk("wdata", 64'(ram_wdata_o), 64'(m_lane(q[0])));
        end else begin
            chk("we_idle", 64'(ram_we_o), 64'h0);
        end
        for (int k = 0; k < 4; k++)
            if (ram_we_o[k]) bram[ram_addr_o[5:2]][8*k +: 8] = ram_wdata_o[8*k +: 8];
        rdy = (q.size() < DEPTH);
        if (q.size() > 0 && g) begin
            s = q.pop_front();
            nb = 1 << s.size;
            for (int k = 0; k < nb; k++) mmem[(int'(s.addr[5:0]) + k) % 64] = s.data[8*k +: 8];
        end
        exp_mis = 1'b0;
        if (v && rdy) begin
            if (m_legal(sz, a)) begin
                s.addr = a; s.size = sz; s.data = d;
                q.push_back(s);
            end else begin
                exp_mis = 1'b1;
                exp_mis_addr = a;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n, input logic g);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0, 32'h0, g, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] d5;
        for (int i = 0; i < 64; i++) mmem[i] = 8'h00;
        for (int i = 0; i < 16; i++) bram[i] = 32'h0;
        rstn_i = 1'b0; st_valid_i = 1'b0; st_size_i = 2'd0; st_addr_i = 32'h0;
        st_wdata_i = 32'h0; ld_valid_i = 1'b0; ld_addr_i = 32'h0; ram_grant_i = 1'b1;
        #8;
        chk("rst_ready", 64'(st_ready_o), 64'h1);
        chk("rst_empty", 64'(empty_o), 64'h1);
        chk("rst_we", 64'(ram_we_o), 64'h0);
        chk("rst_mis", 64'(misaligned_o), 64'h0);
        @(negedge clk_i) rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        // SH pair to word 0 and 1
        step(1'b1, 2'd1, 32'h0, 32'h0000FFFF, 1'b1, 1'b0, 32'h0);
        step(1'b1, 2'd1, 32'h4, 32'h0000FFFF, 1'b1, 1'b0, 32'h0);
        idle(3, 1'b1);

        // SB then SH into the same word
        step(1'b1, 2'd0, 32'h7, 32'h000000A5, 1'b0, 1'b0, 32'h0);
        step(1'b1, 2'd1, 32'h6, 32'h00001234, 1'b0, 1'b0, 32'h0);
        idle(3, 1'b1);

        // Rejects
        step(1'b1, 2'd1, 32'h3, 32'h11111111, 1'b1, 1'b0, 32'h0);
        step(1'b1, 2'd2, 32'h2, 32'h22222222, 1'b1, 1'b0, 32'h0);
        step(1'b1, 2'd3, 32'h20, 32'h33333333, 1'b1, 1'b0, 32'h0);
        idle(2, 1'b1);

        // Fill with grant low, hold the 5th, then drain and wrap
        for (int i = 0; i < 5; i++) step(1'b1, 2'd2, 32'(4*i), $urandom, 1'b0, 1'b0, 32'h0);
        d5 = $urandom;
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 32'h10, d5, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4 && q.size() == DEPTH; i++)
            step(1'b1, 2'd2, 32'h10, d5, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) step(1'b1, 2'd2, 32'((4*i) % 64), $urandom, 1'b1, 1'b0, 32'h0);
        idle(6, 1'b1);

        // Load hazard
        step(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h12);
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h14);
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h12);
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h12);

        // Asynchronous reset mid-cycle with three entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 32'(32 + 4*i), 32'hCAFE0000 + 32'(i), 1'b0, 1'b0, 32'h0);
        st_valid_i = 1'b0; ram_grant_i = 1'b1; ld_valid_i = 1'b1; ld_addr_i = 32'h20;
        #2 rstn_i = 1'b0;
        #1;
        chk("mid_rst_we", 64'(ram_we_o), 64'h0);
        chk("mid_rst_empty", 64'(empty_o), 64'h1);
        chk("mid_rst_ready", 64'(st_ready_o), 64'h1);
        chk("mid_rst_hazard", 64'(ld_hazard_o), 64'h0);
        chk("mid_rst_misaddr", 64'(misaligned_addr_o), 64'h0);
        q.delete();
        exp_mis = 1'b0;
        exp_mis_addr = 32'h0;
        @(negedge clk_i);
        chk("rst_hold_we", 64'(ram_we_o), 64'h0);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Random traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)),
                 $urandom, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 63)));
        idle(DEPTH + 4, 1'b1);

        for (int w = 0; w < 16; w++)
            chk($sformatf("ram[%0d]", w), 64'(bram[w]),
                64'({mmem[4*w+3], mmem[4*w+2], mmem[4*w+1], mmem[4*w]}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jedro_1_store_buffer.md
Name: jedro_1_store_buffer

Overview:
Store-path stage between the jedro_1 execute/LSU store request and the byte-write data RAM port.
- Aligns SB/SH/SW stores into a word address, 4-bit byte-enable and lane-replicated write data.
- Queues stores in a small FIFO and drains one per cycle whenever the RAM port is granted.
- Flags misaligned stores and reports load-after-store address hazards, so the core can stall loads until older stores have drained.

Parameters:
DEPTH, 4, number of buffered stores; power of 2, >= 2.
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes).

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
st_valid_i  in  1  store request valid
st_ready_o  out  1  buffer can accept a store
st_size_i  in  2  mem_size_e: 00 byte, 01 half, 10 word, 11 illegal
st_addr_i  in  ADDR_WIDTH  byte address
st_wdata_i  in  DATA_WIDTH  store data, LSB-justified
misaligned_o  out  1  one-cycle pulse: rejected store
misaligned_addr_o  out  ADDR_WIDTH  address of the last rejected store
ld_valid_i  in  1  core is issuing a load
ld_addr_i  in  ADDR_WIDTH  load byte address
ld_hazard_o  out  1  load word matches a buffered store
empty_o  out  1  no stores pending (fence/drain)
ram_grant_i  in  1  RAM port available for a write this cycle
ram_we_o  out  4  byte write enables
ram_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
ram_wdata_o  out  DATA_WIDTH  lane-replicated write data

Behaviour:
- Reset (asynchronous, rstn_i low), effective immediately mid-operation:
  - all entries discarded; read/write pointers and count = 0;
  - st_ready_o=1, empty_o=1, misaligned_o=0, misaligned_addr_o=0, ram_we_o=0, ld_hazard_o=0.
  - A store in flight during reset is lost; this is required behaviour.
- Alignment (combinational, sub-module), a = st_addr_i[1:0]:
  - byte: be = 4'b0001 << a; wdata = {4{wdata[7:0]}}.
  - half: legal only if a[0]==0; be = 4'b0011 << a; wdata = {2{wdata[15:0]}}.
  - word: legal only if a==0; be = 4'b1111; wdata = wdata.
  - size 11: always illegal.
- Accept:
  - Push on st_valid_i & st_ready_o & legal; entry = {addr[31:2], be, wdata}.
  - st_ready_o = !full. No combinational path from st_valid_i to st_ready_o.
- Reject:
  - On st_valid_i & st_ready_o & !legal, nothing is enqueued.
  - misaligned_o=1 in the next cycle, for exactly one cycle; misaligned_addr_o is registered at the same time and held until the next reject.
  - A request while full is neither accepted nor rejected; the source holds it.
- Drain:
  - ram_we_o = (!empty & ram_grant_i) ? head.be : 0.
  - ram_addr_o = {head.addr, 2'b00}; ram_wdata_o = head.wdata. Both are driven from flops only.
  - Pop when ram_we_o != 0.
- Latency: a store accepted in cycle N appears on the RAM port no earlier than cycle N+1. There is no bypass, including when the buffer is empty.
- Simultaneous push and pop: count is unchanged.
  - Full with a pop: st_ready_o stays 0 that cycle; space shows next cycle.
  - Empty with a push: the entry is visible next cycle.
- Pointers: log2(DEPTH) bits plus a wrap bit; full/empty derived from the wrap bit. Wrap-around must be seamless.
- Ordering: strict FIFO; stores are never merged.
- Hazard:
  - ld_hazard_o = ld_valid_i & OR over valid entries of (entry.addr == ld_addr_i[31:2]).
  - Combinational. The head is included even while it is draining that cycle.
- empty_o = (count==0), registered-state derived.

Decomposition:
- Package jedro_1_lsu_pkg: mem_size_e enum; store_entry_t struct {addr[ADDR_WIDTH-3:0], be[3:0], wdata[31:0]}; BE_* constants.
- Sub-module jedro_1_store_align: combinational size/addr -> {legal, be, replicated wdata}.

Test Plan:
- Reset release, then SH 0x0000FFFF to addr 0 and addr 4 with ram_grant_i=1 -> ram_we_o=0011 at addr 0, then 0011 at addr 4, wdata=0xFFFFFFFF; RAM[0]=RAM[1]=0x0000FFFF; empty_o=1 afterwards.
- SB 0xA5 to addr 0x7, then SH 0x1234 to addr 0x6 -> be=1000 with wdata=0xA5A5A5A5, then be=1100 with wdata=0x12341234, both at ram_addr_o=0x4, in order.
- SH to addr 0x3, SW to addr 0x2, size=11 -> no enqueue; misaligned_o pulses the cycle after each; misaligned_addr_o equals 0x3, then 0x2, then the size-11 address.
- ram_grant_i=0 with 5 SW stores offered and DEPTH=4 -> 4 accepted, st_ready_o=0, the 5th held. Then grant=1 -> drains in order; the 5th is accepted once space appears. Run 12 stores to exercise pointer wrap.
- With buffered SW to addr 0x10, ld_valid_i=1: ld_addr_i=0x12 -> ld_hazard_o=1; ld_addr_i=0x14 -> 0. After the drain, 0x12 -> 0.
- Assert rstn_i low mid-cycle with 3 entries queued -> outputs reset immediately, no RAM write occurs, empty_o=1.
